keypad4x4_scan: RTL and testbench

Scanned 4x4 matrix keypad reader: the input-side counterpart of the multiplexed 7-segment display driver. It drives the keypad rows one at a time, samples the column lines, debounces the result and delivers one ASCII key code per press. Codes use the same ASCII digit encoding the display driver consumes ('0'..'9' = 8'h30..8'h39), so a captured key can be routed straight to a display digit.

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_debounce.sv | 131 +++++++++++++
 rtl/keypad4x4_scan.sv | 114 +++++++++++
 tb/tb_keypad4x4_scan.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the keymap for the 4x4 keypad scanner.
// Codes are ASCII so a captured key can feed a display digit directly.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} kp_state_t;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_kind_t;

  // Indexed [row][col]; row0 is the row driven by row_n = 4'b1110.
  localparam logic [7:0] KEYMAP [0:3][0:3] = '{
    '{8'h31, 8'h32, 8'h33, 8'h41},
    '{8'h34, 8'h35, 8'h36, 8'h42},
    '{8'h37, 8'h38, 8'h39, 8'h43},
    '{8'h2A, 8'h30, 8'h23, 8'h44}
  };

  function automatic logic [7:0] key_ascii(input logic [1:0] row, input logic [1:0] col);
    return KEYMAP[row][col];
  endfunction

  function automatic logic [2:0] col_hits(input logic [3:0] low);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, low[i]};
    return n;
  endfunction

  function automatic logic [1:0] first_col(input logic [3:0] low);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) if (low[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-scan debounce FSM: turns a stream of scan classifications into one
// key event per press, with release debouncing and no rollover.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_end,
  input  scan_kind_t scan_kind,
  input  logic [7:0] scan_code,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output kp_state_t  state_dbg
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  kp_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_down_q, key_down_d;
  logic [3:0] cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  // scan_end is a single-cycle strobe; scan_kind/scan_code are only
  // meaningful in that cycle and there is no back-pressure.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    cnt_inc     = cnt_q + 4'd1;

    if (scan_end) begin
      unique case (state_q)
        IDLE: begin
          if (scan_kind == SINGLE) begin
            if (DB_TARGET == 4'd1) begin
              state_d     = HELD;
              cnt_d       = '0;
              key_code_d  = scan_code;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
            end else begin
              state_d = PRESS;
              cand_d  = scan_code;
              cnt_d   = 4'd1;
            end
          end
        end
        PRESS: begin
          if (scan_kind == SINGLE && scan_code == cand_q) begin
            if (cnt_inc == DB_TARGET) begin
              state_d     = HELD;
              cnt_d       = '0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // A different key restarts from IDLE rather than adopting it.
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (scan_kind == NONE) begin
            if (DB_TARGET == 4'd1) begin
              state_d    = IDLE;
              cnt_d      = '0;
              key_down_d = 1'b0;
            end else begin
              state_d = RELEASE;
              cnt_d   = 4'd1;
            end
          end
        end
        RELEASE: begin
          if (scan_kind == NONE) begin
            if (cnt_inc == DB_TARGET) begin
              state_d    = IDLE;
              cnt_d      = '0;
              key_down_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/keypad4x4_scan.sv
// 4x4 matrix keypad reader: rotates the active-low row drive, synchronizes
// and samples the columns once per row slot, and classifies each full scan.
module keypad4x4_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int              SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  logic [3:0]        col_meta_q, col_sync_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        row_n_q, row_n_d;
  logic [1:0]        hit_cnt_q, hit_cnt_d;
  logic [7:0]        hit_code_q, hit_code_d;

  logic       slot_end, scan_end;
  logic [3:0] cols_low;
  logic [2:0] row_hits, hit_total;
  logic [1:0] hit_sat;
  logic [7:0] merged_code;
  scan_kind_t scan_kind;
  kp_state_t  deb_state;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
      slot_q     <= '0;
      row_idx_q  <= 2'd0;
      row_n_q    <= 4'b1110;
      hit_cnt_q  <= 2'd0;
      hit_code_q <= 8'h00;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
      slot_q     <= slot_d;
      row_idx_q  <= row_idx_d;
      row_n_q    <= row_n_d;
      hit_cnt_q  <= hit_cnt_d;
      hit_code_q <= hit_code_d;
    end
  end

  always_comb begin
    slot_end  = (slot_q == SLOT_LAST);
    scan_end  = slot_end && (row_idx_q == 2'd3);
    cols_low  = ~col_sync_q;
    row_hits  = col_hits(cols_low);
    // Hit count saturates at 2: anything beyond one intersection is MULTI.
    hit_total = 3'(hit_cnt_q) + row_hits;
    hit_sat   = (hit_total >= 3'd2) ? 2'd2 : hit_total[1:0];
    merged_code = (row_hits == 3'd1) ? key_ascii(row_idx_q, first_col(cols_low)) : hit_code_q;

    slot_d     = slot_q + 1'b1;
    row_idx_d  = row_idx_q;
    row_n_d    = row_n_q;
    hit_cnt_d  = hit_cnt_q;
    hit_code_d = hit_code_q;
    scan_kind  = NONE;

    if (slot_end) begin
      slot_d    = '0;
      row_idx_d = row_idx_q + 2'd1;
      row_n_d   = {row_n_q[2:0], row_n_q[3]};
      if (scan_end) begin
        hit_cnt_d  = 2'd0;
        hit_code_d = 8'h00;
        unique case (hit_sat)
          2'd0:    scan_kind = NONE;
          2'd1:    scan_kind = SINGLE;
          default: scan_kind = MULTI;
        endcase
      end else begin
        hit_cnt_d  = hit_sat;
        hit_code_d = merged_code;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (Clk),
    .rst       (Rst),
    .scan_end  (scan_end),
    .scan_kind (scan_kind),
    .scan_code (merged_code),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .state_dbg (deb_state)
  );

  assign row_n = row_n_q;

  a_row_onehot_low : assert property (@(posedge Clk) disable iff (Rst) $onehot(~row_n_q));
  a_row_matches_idx : assert property (@(posedge Clk) disable iff (Rst)
    row_n_q == ~(4'b0001 << row_idx_q));
  a_down_tracks_state : assert property (@(posedge Clk) disable iff (Rst)
    key_down == (deb_state inside {HELD, RELEASE}));

endmodule

// File: tb/tb_keypad4x4_scan.sv
// Bench for keypad4x4_scan: a keypad environment model drives col_n from the
// pressed-key mask, and a streak-based reference model predicts key events.
module tb_keypad4x4_scan;

  localparam int SCAN_DIV = 8;
  localparam int DB       = 3;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] row_n, col_n;
  logic [7:0] key_code;
  logic       key_valid, key_down;

  logic [15:0] pressed;
  int          n_checks = 0;
  int          n_errors = 0;

  string      keymap_s = "123A456B789C*0#D";
  logic       m_held;
  int         m_streak;
  logic [7:0] m_cand, m_code;
  logic       m_valid;
  logic [7:0] exp_q[$];

  keypad4x4_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // Pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!row_n[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] m;
    m = 16'h0001;
    return m << (r * 4 + c);
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_held   = 1'b0;
    m_streak = 0;
    m_cand   = 8'h00;
    m_code   = 8'h00;
    m_valid  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_scan(input logic [15:0] keys);
    int         n;
    logic [7:0] code;
    n       = $countones(keys);
    code    = 8'h00;
    m_valid = 1'b0;
    for (int i = 0; i < 16; i++) if (keys[i]) code = keymap_s[i];
    if (!m_held) begin
      if (n == 1) begin
        if (m_streak > 0 && code == m_cand) m_streak++;
        else if (m_streak == 0) begin
          m_streak = 1;
          m_cand   = code;
        end else m_streak = 0;
      end else m_streak = 0;
      if (m_streak == DB) begin
        m_held   = 1'b1;
        m_streak = 0;
        m_code   = m_cand;
        m_valid  = 1'b1;
        exp_q.push_back(m_cand);
      end
    end else begin
      if (n == 0) m_streak++;
      else m_streak = 0;
      if (m_streak == DB) begin
        m_held   = 1'b0;
        m_streak = 0;
      end
    end
  endtask

  // ---------------- driver: one full scan with a fixed key mask ----------------
  task automatic run_scan(input logic [15:0] keys);
    int         row_err;
    logic [3:0] one, exp_row;
    row_err = 0;
    one     = 4'b0001;
    pressed = keys;
    for (int i = 0; i < SCAN_CYC; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      exp_row = ~(one << (((i + 1) / SCAN_DIV) % 4));
      if (row_n !== exp_row) row_err++;
      if (i == SCAN_CYC - 1) begin
        model_scan(keys);
        check("valid_at_scan_end", key_valid, m_valid);
        check("key_down", key_down, m_held);
        check("key_code_held", key_code, m_code);
      end
      if (key_valid) begin
        if (exp_q.size() == 0) check("spurious_valid", key_valid, 1'b0);
        else check("valid_code", key_code, exp_q.pop_front());
      end
    end
    check("row_rotation", row_err, 0);
    check("sb_drain", exp_q.size(), 0);
  endtask

  task automatic run_scans(input logic [15:0] keys, input int n);
    for (int s = 0; s < n; s++) run_scan(keys);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] mask;
    int          kind, len, a, b;

    Rst     = 1'b1;
    pressed = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_row_n", row_n, 4'b1110);
    check("rst_key_code", key_code, 8'h00);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_down", key_down, 1'b0);
    Rst = 1'b0;

    // clean press '6', then release, then '0'
    run_scans(key(1, 2), 5);
    run_scans(16'h0000, 4);
    run_scans(key(3, 1), 4);
    run_scans(16'h0000, 4);

    // bounce on '5', then hold
    for (int s = 0; s < 6; s++) run_scan((s % 2 == 0) ? key(1, 1) : 16'h0000);
    run_scans(key(1, 1), 4);
    run_scans(16'h0000, 4);

    // two keys together never accepted
    run_scans(key(0, 0) | key(2, 2), 4);
    run_scans(16'h0000, 2);

    // rollover: 'A' accepted, then 'D' added and 'A' released
    run_scans(key(0, 3), 4);
    run_scans(key(0, 3) | key(3, 3), 2);
    run_scans(key(3, 3), 3);
    run_scans(16'h0000, 4);

    // release glitch: 2 empty scans then the key again
    run_scans(key(0, 1), 4);
    run_scans(16'h0000, 2);
    run_scan(key(0, 1));
    run_scans(16'h0000, 4);

    // asynchronous reset mid-slot while a press is being debounced
    pressed = key(2, 0);
    repeat (13) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    #2 Rst = 1'b1;
    #1;
    check("midrst_row_n", row_n, 4'b1110);
    check("midrst_key_code", key_code, 8'h00);
    check("midrst_key_valid", key_valid, 1'b0);
    check("midrst_key_down", key_down, 1'b0);
    repeat (2) begin
      @(negedge Clk);
      check("inrst_key_valid", key_valid, 1'b0);
    end
    Rst = 1'b0;
    model_reset();
    run_scans(key(2, 0), 4);
    run_scans(16'h0000, 4);

    // randomized runs of none / single / multi patterns
    for (int r = 0; r < 16; r++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      mask = 16'h0000;
      if (kind == 1 || kind == 2) mask[a] = 1'b1;
      else if (kind == 3) begin
        mask[a] = 1'b1;
        mask[b] = 1'b1;
      end
      run_scans(mask, len);
    end
    run_scans(16'h0000, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
